// File: rtl/pll_rst_ctrl_if.sv
// PLL reset controller bundle: lock/soft-restart inputs and the reset/status outputs.
// master = controller side, slave = PLL/system side.
interface pll_rst_ctrl_if;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       rst_cfg;
    logic       sys_rst;
    logic       lock_err;
    logic       lock_loss;
    logic [3:0] retry_cnt;
    logic [2:0] state_o;

    modport master (
        input  pll_locked, soft_rst_req,
        output pll_rst, rst_cfg, sys_rst, lock_err, lock_loss, retry_cnt, state_o
    );

    modport slave (
        output pll_locked, soft_rst_req,
        input  pll_rst, rst_cfg, sys_rst, lock_err, lock_loss, retry_cnt, state_o
    );
endinterface

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulse PLL reset, qualify lock, then release cfg and system resets in order.
// Latency: pll_locked sees 2 sync cycles; every output is registered from the next state.
// No backpressure: soft_rst_req is a single-cycle request and always wins.
module pll_rst_ctrl #(
    parameter int U_DLY            = 1,
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int SEQ_GAP_CYC      = 256,
    parameter int MAX_RETRY        = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    pll_rst_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_PLL_RST     = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_REL_CFG     = 3'd3,
        ST_RUN         = 3'd4,
        ST_FAIL        = 3'd5
    } state_t;

    localparam logic [16:0] PULSE_LAST   = 17'(RST_PULSE_CYC - 1);
    localparam logic [16:0] TIMEOUT_LAST = 17'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [16:0] STABLE_LAST  = 17'(LOCK_STABLE_CYC - 1);
    localparam logic [16:0] GAP_LAST     = 17'(SEQ_GAP_CYC - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

    if (U_DLY < 0 || RST_PULSE_CYC < 2 || LOCK_STABLE_CYC < 2 || LOCK_TIMEOUT_CYC < 2 ||
        LOCK_TIMEOUT_CYC > 131072 || SEQ_GAP_CYC < 1 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_param_chk
        $error("pll_rst_ctrl: parameter out of range");
    end

    logic        lock_meta;
    logic        lock_s;
    state_t      state_q;
    state_t      state_d;
    logic [16:0] cnt_q;
    logic [16:0] cnt_d;
    logic [3:0]  retry_q;
    logic [3:0]  retry_d;
    logic        lock_loss_d;
    logic        cnt_run;
    logic        fail_ev;
    logic        pll_rst_q;
    logic        rst_cfg_q;
    logic        sys_rst_q;
    logic        lock_err_q;
    logic        lock_loss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        lock_loss_d = 1'b0;
        cnt_run     = 1'b0;
        fail_ev     = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                cnt_run = 1'b1;
                if (cnt_q == PULSE_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                cnt_run = 1'b1;
                if (lock_s)                       state_d = ST_LOCK_STABLE;
                else if (cnt_q == TIMEOUT_LAST)   fail_ev = 1'b1;
            end
            ST_LOCK_STABLE: begin
                cnt_run = 1'b1;
                // Lock drop beats a simultaneous terminal count.
                if (!lock_s)                      fail_ev = 1'b1;
                else if (cnt_q == STABLE_LAST)    state_d = ST_REL_CFG;
            end
            ST_REL_CFG: begin
                cnt_run = 1'b1;
                if (!lock_s) begin
                    state_d     = ST_PLL_RST;
                    lock_loss_d = 1'b1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d     = ST_PLL_RST;
                    lock_loss_d = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: state_d = ST_PLL_RST;
        endcase

        if (fail_ev) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = ST_PLL_RST;
            end else begin
                state_d = ST_FAIL;
            end
        end

        if (bus.soft_rst_req) begin
            state_d     = ST_PLL_RST;
            retry_d     = 4'd0;
            lock_loss_d = 1'b0;
        end

        // Counter only runs in bounded states, so it never wraps.
        cnt_d = cnt_run ? cnt_q + 17'd1 : cnt_q;
        if (bus.soft_rst_req || (state_d != state_q)) cnt_d = 17'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= 17'd0;
            retry_q     <= 4'd0;
            pll_rst_q   <= 1'b1;
            rst_cfg_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            lock_err_q  <= 1'b0;
            lock_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
            rst_cfg_q   <= !((state_d == ST_REL_CFG) || (state_d == ST_RUN));
            sys_rst_q   <= (state_d != ST_RUN);
            lock_err_q  <= (state_d == ST_FAIL);
            lock_loss_q <= lock_loss_d;
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.rst_cfg   = rst_cfg_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.lock_err  = lock_err_q;
    assign bus.lock_loss = lock_loss_q;
    assign bus.retry_cnt = retry_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl with short sequence parameters.
// Outputs sampled 1ns after each rising edge; inputs driven at the same point.
module tb_pll_rst_ctrl;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   viol_sys;
    int   viol_pll;
    int   n;

    pll_rst_ctrl_if bus();

    pll_rst_ctrl #(
        .U_DLY            (1),
        .RST_PULSE_CYC    (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (32),
        .SEQ_GAP_CYC      (4),
        .MAX_RETRY        (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // 0..4 select a status bit; 10+s selects "state_o == s".
    function automatic bit cond(input int k);
        case (k)
            0:       return bus.pll_rst;
            1:       return bus.rst_cfg;
            2:       return bus.sys_rst;
            3:       return bus.lock_err;
            4:       return bus.lock_loss;
            default: return (bus.state_o == 3'(k - 10));
        endcase
    endfunction

    task automatic wait_until(input int k, input bit val, input int bound, input string tag,
                              output int cyc);
        cyc = 0;
        while (cond(k) !== val && cyc < bound) begin
            step(1);
            cyc++;
        end
        if (cond(k) !== val) chk({tag, "_timeout"}, 32'(cond(k)), 32'(val));
    endtask

    task automatic chk_rst(input string p);
        chk({p, "_state"},     32'(bus.state_o),   32'd0);
        chk({p, "_pll_rst"},   32'(bus.pll_rst),   32'd1);
        chk({p, "_rst_cfg"},   32'(bus.rst_cfg),   32'd1);
        chk({p, "_sys_rst"},   32'(bus.sys_rst),   32'd1);
        chk({p, "_lock_err"},  32'(bus.lock_err),  32'd0);
        chk({p, "_lock_loss"}, 32'(bus.lock_loss), 32'd0);
        chk({p, "_retry"},     32'(bus.retry_cnt), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rst_cfg && !bus.sys_rst) viol_sys++;
            if (bus.pll_rst && !bus.rst_cfg) viol_pll++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0; viol_sys = 0; viol_pll = 0; n = 0;
        rst_n = 1'b0;
        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b0;
        step(3);
        chk_rst("rst");

        // Nominal bring-up, lock arrives 10 cycles after release
        rst_n = 1'b1;
        wait_until(0, 1'b0, 20, "pulse0", n);
        chk("pulse0_len", 32'(n), 32'd4);
        chk("st_wait", 32'(bus.state_o), 32'd1);
        step(6);
        bus.pll_locked = 1'b1;
        wait_until(12, 1'b1, 10, "sync", n);
        chk("sync_lat", 32'(n), 32'd3);
        wait_until(1, 1'b0, 20, "stable", n);
        chk("stable_len", 32'(n), 32'd8);
        chk("rel_sys_rst", 32'(bus.sys_rst), 32'd1);
        chk("st_rel", 32'(bus.state_o), 32'd3);
        wait_until(2, 1'b0, 20, "gap", n);
        chk("gap_len", 32'(n), 32'd4);
        chk("st_run", 32'(bus.state_o), 32'd4);
        chk("run_retry", 32'(bus.retry_cnt), 32'd0);
        chk("run_pll_rst", 32'(bus.pll_rst), 32'd0);

        // Lock loss while running
        bus.pll_locked = 1'b0;
        wait_until(4, 1'b1, 10, "loss", n);
        chk("loss_lat", 32'(n), 32'd3);
        chk("loss_rst_cfg", 32'(bus.rst_cfg), 32'd1);
        chk("loss_sys_rst", 32'(bus.sys_rst), 32'd1);
        chk("loss_state", 32'(bus.state_o), 32'd0);
        chk("loss_retry", 32'(bus.retry_cnt), 32'd0);
        step(1);
        chk("loss_pulse_end", 32'(bus.lock_loss), 32'd0);

        // One-cycle lock glitch at stable count 5
        bus.pll_locked = 1'b1;
        wait_until(12, 1'b1, 20, "g_stable", n);
        step(3);
        bus.pll_locked = 1'b0;
        step(1);
        bus.pll_locked = 1'b1;
        wait_until(0, 1'b1, 10, "glitch", n);
        chk("glitch_lat", 32'(n), 32'd2);
        chk("glitch_retry", 32'(bus.retry_cnt), 32'd1);
        chk("glitch_rst_cfg", 32'(bus.rst_cfg), 32'd1);
        wait_until(0, 1'b0, 10, "g_pulse", n);
        chk("g_pulse_len", 32'(n), 32'd4);
        wait_until(1, 1'b0, 40, "g_rel", n);
        chk("g_rel_state", 32'(bus.state_o), 32'd3);
        wait_until(2, 1'b0, 20, "g_run", n);
        chk("g_run_state", 32'(bus.state_o), 32'd4);
        chk("g_run_retry", 32'(bus.retry_cnt), 32'd0);

        // Soft request coinciding with the REL_CFG terminal count
        bus.pll_locked = 1'b0;
        wait_until(4, 1'b1, 10, "loss2", n);
        bus.pll_locked = 1'b1;
        wait_until(13, 1'b1, 60, "e_rel", n);
        step(3);
        bus.soft_rst_req = 1'b1;
        step(1);
        bus.soft_rst_req = 1'b0;
        chk("soft_rel_state", 32'(bus.state_o), 32'd0);
        chk("soft_rel_lock_err", 32'(bus.lock_err), 32'd0);
        chk("soft_rel_retry", 32'(bus.retry_cnt), 32'd0);
        chk("soft_rel_rst_cfg", 32'(bus.rst_cfg), 32'd1);
        chk("soft_rel_sys_rst", 32'(bus.sys_rst), 32'd1);

        // Asynchronous reset in the middle of LOCK_STABLE
        wait_until(12, 1'b1, 20, "f_stable", n);
        step(2);
        rst_n = 1'b0;
        bus.pll_locked = 1'b0;
        #1;
        chk_rst("arst");
        step(2);
        rst_n = 1'b1;

        // No lock at all: three attempts, then FAIL
        for (int a = 0; a < 3; a++) begin
            wait_until(0, 1'b0, 20, "to_pulse", n);
            chk("to_pulse_len", 32'(n), 32'd4);
            if (a < 2) wait_until(0, 1'b1, 50, "to_wait", n);
            else       wait_until(15, 1'b1, 50, "to_wait", n);
            chk("to_wait_len", 32'(n), 32'd32);
            chk("to_retry", 32'(bus.retry_cnt), 32'((a < 2) ? a + 1 : 2));
        end
        chk("fail_lock_err", 32'(bus.lock_err), 32'd1);
        chk("fail_pll_rst", 32'(bus.pll_rst), 32'd1);
        chk("fail_rst_cfg", 32'(bus.rst_cfg), 32'd1);
        chk("fail_sys_rst", 32'(bus.sys_rst), 32'd1);
        step(10);
        chk("fail_hold", 32'(bus.state_o), 32'd5);
        chk("fail_hold_err", 32'(bus.lock_err), 32'd1);

        // Soft request leaves FAIL; a second one restarts the pulse count
        bus.soft_rst_req = 1'b1;
        step(1);
        bus.soft_rst_req = 1'b0;
        chk("soft_fail_state", 32'(bus.state_o), 32'd0);
        chk("soft_fail_lock_err", 32'(bus.lock_err), 32'd0);
        chk("soft_fail_retry", 32'(bus.retry_cnt), 32'd0);
        chk("soft_fail_rst_cfg", 32'(bus.rst_cfg), 32'd1);
        chk("soft_fail_pll_rst", 32'(bus.pll_rst), 32'd1);
        step(2);
        bus.soft_rst_req = 1'b1;
        step(1);
        bus.soft_rst_req = 1'b0;
        wait_until(0, 1'b0, 20, "restart", n);
        chk("restart_len", 32'(n), 32'd4);

        chk("inv_cfg_sys", 32'(viol_sys), 32'd0);
        chk("inv_pll_cfg", 32'(viol_pll), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pll_rst_ctrl.md
PLL_RST_CTRL -- requirements
Module: pll_rst_ctrl

Interface
REQ-001 Parameter U_DLY, 1, register update delay (ns) for simulation.
REQ-002 Parameter RST_PULSE_CYC, 16, PLL reset pulse width in clk cycles (>=2).
REQ-003 Parameter LOCK_STABLE_CYC, 1024, consecutive locked cycles required before release (>=2).
REQ-004 Parameter LOCK_TIMEOUT_CYC, 65536, max cycles waiting for lock per attempt (>=2, <=2^17).
REQ-005 Parameter SEQ_GAP_CYC, 256, cycles between rst_cfg release and sys_rst release (>=1).
REQ-006 Parameter MAX_RETRY, 7, failed attempts tolerated before FAIL (1..15).
REQ-007 clk  input  1  free-running reference oscillator clock; sole clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 pll_locked  input  1  PLL lock indicator, asynchronous to clk.
REQ-010 soft_rst_req  input  1  synchronous single-cycle request to restart the sequence.
REQ-011 pll_rst  output  1  active-high reset to PLL.
REQ-012 rst_cfg  output  1  active-high config-domain reset request.
REQ-013 sys_rst  output  1  active-high system-domain reset request.
REQ-014 lock_err  output  1  sticky; retries exhausted.
REQ-015 lock_loss  output  1  one-cycle pulse on lock loss after release.
REQ-016 retry_cnt  output  4  consecutive failed attempts.
REQ-017 state_o  output  3  current state code.

Function
REQ-018 pll_locked SHALL pass a 2-flop synchronizer (lock_s) before any use; 2-cycle input latency.
REQ-019 States/codes: PLL_RST=0, WAIT_LOCK=1, LOCK_STABLE=2, REL_CFG=3, RUN=4, FAIL=5; codes 6-7 SHALL recover to PLL_RST.
REQ-020 All outputs SHALL be registered; output changes appear the cycle after the state transition.
REQ-021 PLL_RST: pll_rst=1, rst_cfg=1, sys_rst=1; after exactly RST_PULSE_CYC cycles -> WAIT_LOCK, counter cleared.
REQ-022 WAIT_LOCK: pll_rst=0; lock_s=1 -> LOCK_STABLE, counter cleared; counter reaching LOCK_TIMEOUT_CYC-1 with lock_s=0 -> failure.
REQ-023 LOCK_STABLE: lock_s=0 -> failure; LOCK_STABLE_CYC consecutive lock_s=1 cycles -> REL_CFG, counter cleared.
REQ-024 Failure: retry_cnt<MAX_RETRY -> retry_cnt+1, go PLL_RST; retry_cnt==MAX_RETRY -> FAIL.
REQ-025 REL_CFG: rst_cfg=0, sys_rst=1; after SEQ_GAP_CYC cycles -> RUN.
REQ-026 RUN: rst_cfg=0, sys_rst=0; retry_cnt cleared to 0 on entry.
REQ-027 lock_s=0 in REL_CFG or RUN -> PLL_RST; rst_cfg and sys_rst reassert next cycle; lock_loss pulses 1 cycle; retry_cnt unchanged.
REQ-028 FAIL: pll_rst=1, rst_cfg=1, sys_rst=1, lock_err=1; held until rst_n or soft_rst_req.
REQ-029 soft_rst_req=1 in any state SHALL take priority over all transitions: next state PLL_RST, counter, retry_cnt and lock_err cleared; in PLL_RST it restarts the pulse count.
REQ-030 Simultaneous lock loss and counter terminal count SHALL resolve as lock loss/failure.
REQ-031 Single shared 17-bit counter SHALL clear on every state change; no wrap within any state.
REQ-032 rst_cfg and sys_rst SHALL never deassert while pll_rst=1 or before LOCK_STABLE completes; sys_rst SHALL never be 0 while rst_cfg=1.

Reset
REQ-033 rst_n=0 SHALL asynchronously force: state PLL_RST, pll_rst=1, rst_cfg=1, sys_rst=1, lock_err=0, lock_loss=0, retry_cnt=0, state_o=0, counter=0, synchronizer flops=0.
REQ-034 Deassertion of rst_n SHALL be synchronous to clk (user provides sync release); sequence starts in the first clk after release.

Verification (bench params: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, SEQ_GAP_CYC=4, MAX_RETRY=2)
REQ-035 Nominal: pll_locked=1 from cycle 10 -> pll_rst high 4 cycles, rst_cfg falls 8 cycles after lock_s, sys_rst 4 cycles later, state_o=4, retry_cnt=0.
REQ-036 Timeout: pll_locked=0 forever -> three 4-cycle pll_rst pulses spaced 32 waits, retry_cnt 0->1->2, then state_o=5, lock_err=1, pll_rst=1.
REQ-037 Glitch: lock drops for 1 cycle at stable count 5 -> no release, retry_cnt=1, new pll_rst pulse, then nominal release.
REQ-038 Lock loss in RUN: pll_locked 0 -> lock_loss pulse 1 cycle, rst_cfg=sys_rst=1 next cycle, state_o=0, retry_cnt=0.
REQ-039 soft_rst_req in FAIL and simultaneously with terminal count in REL_CFG -> state_o=0, lock_err=0, retry_cnt=0, rst_cfg=1.
REQ-040 rst_n asserted mid-LOCK_STABLE -> all outputs at REQ-033 values immediately, without waiting for clk.
